// File: rtl/piramide_dec_if.sv
// Sample/status bundle between a piramide stream source and piramide_decoder.
// The peak_chg wire exists only when PIRAMIDE_DEC_CHANGE_EN is defined.
interface piramide_dec_if #(
  parameter int W  = 4,
  parameter int CW = 6,
  parameter int EW = 4
);
  logic [W-1:0]  sample;
  logic [W-1:0]  peak;
  logic          peak_valid;
  logic          dir;
  logic          locked;
  logic [CW-1:0] period;
  logic          err;
  logic [EW-1:0] err_cnt;
`ifdef PIRAMIDE_DEC_CHANGE_EN
  logic          peak_chg;
`endif

  modport master (
    output sample,
    input  peak, peak_valid, dir, locked, period, err, err_cnt
`ifdef PIRAMIDE_DEC_CHANGE_EN
    , input peak_chg
`endif
  );

  modport slave (
    input  sample,
    output peak, peak_valid, dir, locked, period, err, err_cnt
`ifdef PIRAMIDE_DEC_CHANGE_EN
    , output peak_chg
`endif
  );
endinterface

// File: rtl/piramide_decoder.sv
// Triangle-stream decoder: recovers peak, period and direction from a piramide
// output stream and flags sequence breaks. Optional macro: PIRAMIDE_DEC_CHANGE_EN.
module piramide_decoder #(
  parameter int W  = 4,
  parameter int CW = 6,
  parameter int EW = 4
) (
  input  logic           clk,
  input  logic           rst,
  piramide_dec_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  function automatic logic [EW-1:0] err_inc(input logic [EW-1:0] v);
    return (v == {EW{1'b1}}) ? v : v + EW'(1);
  endfunction

  logic [1:0]    state_q,   state_d;
  logic [W-1:0]  prev_q,    prev_d;
  logic [W-1:0]  peak_q,    peak_d;
  logic          pv_q,      pv_d;
  logic          dir_q,     dir_d;
  logic          locked_q,  locked_d;
  logic [CW-1:0] period_q,  period_d;
  logic          err_q,     err_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          have_q,    have_d;
  logic          chg_q,     chg_d;

  logic          is_inc, is_dec, viol;

  // Width-extended compare so prev==2**W-1 can never match an increment.
  assign is_inc = ({1'b0, bus.sample} == ({1'b0, prev_q} + (W+1)'(1)));
  assign is_dec = (prev_q != '0) && (bus.sample == prev_q - W'(1));

  always_comb begin
    state_d   = state_q;
    prev_d    = bus.sample;
    peak_d    = peak_q;
    pv_d      = 1'b0;
    period_d  = period_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    cnt_d     = locked_q ? cnt_inc(cnt_q) : cnt_q;
    have_d    = have_q;
    chg_d     = 1'b0;
    viol      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.sample == '0) begin
          state_d = S_UP;
          cnt_d   = '0;
          have_d  = 1'b0;
        end
      end
      S_UP: begin
        if (is_inc) begin
          state_d = S_UP;
        end else if (is_dec) begin
          state_d = S_DOWN;
          peak_d  = prev_q;
          pv_d    = 1'b1;
          chg_d   = have_q && (prev_q != peak_q);
          if (have_q) period_d = cnt_inc(cnt_q);
          cnt_d   = '0;
          have_d  = 1'b1;
        end else if ((bus.sample == '0) && (prev_q == '0)) begin
          // max=0: every flat zero sample is its own peak.
          peak_d   = '0;
          pv_d     = 1'b1;
          chg_d    = have_q && (peak_q != '0);
          period_d = CW'(1);
          cnt_d    = '0;
          have_d   = 1'b1;
        end else begin
          viol = 1'b1;
        end
      end
      S_DOWN: begin
        if (is_dec) begin
          state_d = S_DOWN;
        end else if ((prev_q == '0) && (bus.sample == W'(1))) begin
          state_d = S_UP;
        end else begin
          viol = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (viol) begin
      state_d   = S_IDLE;
      err_d     = 1'b1;
      err_cnt_d = err_inc(err_cnt_q);
    end

    dir_d    = (state_d == S_UP);
    locked_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prev_q    <= '0;
      peak_q    <= '0;
      pv_q      <= 1'b0;
      dir_q     <= 1'b0;
      locked_q  <= 1'b0;
      period_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      cnt_q     <= '0;
      have_q    <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      peak_q    <= peak_d;
      pv_q      <= pv_d;
      dir_q     <= dir_d;
      locked_q  <= locked_d;
      period_q  <= period_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      cnt_q     <= cnt_d;
      have_q    <= have_d;
      chg_q     <= chg_d;
    end
  end

  assign bus.peak       = peak_q;
  assign bus.peak_valid = pv_q;
  assign bus.dir        = dir_q;
  assign bus.locked     = locked_q;
  assign bus.period     = period_q;
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;

`ifdef PIRAMIDE_DEC_CHANGE_EN
  assign bus.peak_chg   = chg_q;
`else
  logic unused_chg;
  assign unused_chg = chg_q;
`endif

endmodule

// File: tb/tb_piramide_decoder.sv
// Directed bench for piramide_decoder: a per-cycle vector table for the max=7
// stream plus hand-written sequences for the degenerate, wrap, error and reset cases.
module tb_piramide_decoder;

  logic clk;
  logic rst;

  piramide_dec_if #(.W(4), .CW(6), .EW(4)) bus ();

  piramide_decoder #(.W(4), .CW(6), .EW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic [3:0] s;
    logic [3:0] pk;
    logic       pv;
    logic       dir;
    logic       lk;
    logic [5:0] per;
    logic       err;
    logic [3:0] ec;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] s, input logic [3:0] pk,
                     input logic pv, input logic dir, input logic lk,
                     input logic [5:0] per, input logic err, input logic [3:0] ec);
    vec_t v;
    v.r = r; v.s = s; v.pk = pk; v.pv = pv; v.dir = dir; v.lk = lk;
    v.per = per; v.err = err; v.ec = ec;
    vq.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] s);
    @(negedge clk);
    rst        = r;
    bus.sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] act, exp;
    rst        = 1'b1;
    bus.sample = '0;

    // max=7: 0..7, 6..0, 1..7, 6 with outputs as seen after each edge
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 7; i++) add(0, 4'(i), 0, 0, 1, 1, 0, 0, 0);
    add(0, 6, 7, 1, 0, 1, 0, 0, 0);
    for (int i = 5; i >= 0; i--) add(0, 4'(i), 7, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 4'(i), 7, 0, 1, 1, 0, 0, 0);
    add(0, 6, 7, 1, 0, 1, 14, 0, 0);
    add(0, 5, 7, 0, 0, 1, 14, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].s);
      act = {bus.peak, bus.peak_valid, bus.dir, bus.locked, bus.period, bus.err, bus.err_cnt};
      exp = {vq[i].pk, vq[i].pv, vq[i].dir, vq[i].lk, vq[i].per, vq[i].err, vq[i].ec};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h", i, act, exp);
      end
    end

    // max=0: constant zero stream
    do_reset();
    step(0, 0);
    chk("m0_lock", int'(bus.locked), 1);
    chk("m0_pv_first", int'(bus.peak_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      chk("m0_pv", int'(bus.peak_valid), 1);
      chk("m0_per", int'(bus.period), 1);
      chk("m0_err", int'(bus.err), 0);
    end
    chk("m0_peak", int'(bus.peak), 0);

    // max=15: no wrap past 15, period 30
    do_reset();
    for (int i = 0; i <= 15; i++) step(0, 4'(i));
    chk("m15_top_dir", int'(bus.dir), 1);
    chk("m15_top_err", int'(bus.err), 0);
    step(0, 14);
    chk("m15_pk1", int'(bus.peak), 15);
    chk("m15_pv1", int'(bus.peak_valid), 1);
    chk("m15_per1", int'(bus.period), 0);
    for (int i = 13; i >= 0; i--) step(0, 4'(i));
    for (int i = 1; i <= 15; i++) step(0, 4'(i));
    step(0, 14);
    chk("m15_pv2", int'(bus.peak_valid), 1);
    chk("m15_per2", int'(bus.period), 30);
    chk("m15_err", int'(bus.err_cnt), 0);
    step(0, 0);
    chk("m15_wrap_err", int'(bus.err), 1);

    // skip 0,1,3,4 then resume 0,1,2,1
    do_reset();
    step(0, 0);
    step(0, 1);
    step(0, 3);
    chk("skip_err", int'(bus.err), 1);
    chk("skip_ecnt", int'(bus.err_cnt), 1);
    chk("skip_lock", int'(bus.locked), 0);
    step(0, 4);
    chk("skip_err_pulse", int'(bus.err), 0);
    chk("skip_idle", int'(bus.locked), 0);
    step(0, 0);
    chk("relock", int'(bus.locked), 1);
    step(0, 1);
    step(0, 2);
    step(0, 1);
    chk("relock_pv", int'(bus.peak_valid), 1);
    chk("relock_pk", int'(bus.peak), 2);
    chk("relock_ecnt", int'(bus.err_cnt), 1);

    // reset in DOWN at sample 4 of max=7
    do_reset();
    for (int i = 0; i <= 7; i++) step(0, 4'(i));
    for (int i = 6; i >= 4; i--) step(0, 4'(i));
    chk("pre_rst_pk", int'(bus.peak), 7);
    step(1, 4);
    act = {bus.peak, bus.peak_valid, bus.dir, bus.locked, bus.period, bus.err, bus.err_cnt};
    chk("midrst_outs", int'(act), 0);
    for (int i = 0; i <= 7; i++) step(0, 4'(i));
    step(0, 6);
    chk("post_rst_pk", int'(bus.peak), 7);
    chk("post_rst_pv", int'(bus.peak_valid), 1);
    chk("post_rst_per", int'(bus.period), 0);

`ifdef PIRAMIDE_DEC_CHANGE_EN
    // max 5 then 3 after a valley
    do_reset();
    for (int i = 0; i <= 5; i++) step(0, 4'(i));
    step(0, 4);
    chk("chg_first", int'(bus.peak_chg), 0);
    for (int i = 3; i >= 0; i--) step(0, 4'(i));
    for (int i = 1; i <= 3; i++) step(0, 4'(i));
    step(0, 2);
    chk("chg_pk", int'(bus.peak), 3);
    chk("chg_set", int'(bus.peak_chg), 1);
    chk("chg_err", int'(bus.err), 0);
    step(0, 1);
    chk("chg_pulse", int'(bus.peak_chg), 0);
    step(0, 0);
    for (int i = 1; i <= 3; i++) step(0, 4'(i));
    step(0, 2);
    chk("chg_same_pv", int'(bus.peak_valid), 1);
    chk("chg_same", int'(bus.peak_chg), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
